// File: rtl/wb_boot_copier.sv
// Wishbone pipelined bus master that copies len 32-bit words from src to dst.
// Define WB_BOOT_COPIER_VERIFY_EN to read every written word back and compare it.
module wb_boot_copier #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int LW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            start_i,
    input  logic [AW-1:0]   src_i,
    input  logic [AW-1:0]   dst_i,
    input  logic [LW-1:0]   len_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o,
    output logic [AW-1:0]   err_addr_o,
    output logic [AW-1:0]   wb_adr_o,
    output logic [DW-1:0]   wb_dat_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic            wb_we_o,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic            wb_stall_i,
    input  logic            wb_ack_i,
    input  logic            wb_err_i
);

    localparam int WDW = (TIMEOUT > 32'sd1) ? $clog2(TIMEOUT) : 1;
    localparam bit WD_EN = (TIMEOUT > 32'sd0);
    localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 32'sd0) ? TIMEOUT - 32'sd1 : 32'sd0);
    localparam logic [AW-1:0] WORD_STEP = AW'(32'd4);

`ifdef WB_BOOT_COPIER_VERIFY_EN
    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_RD_REQ  = 4'd1,
        ST_RD_WAIT = 4'd2,
        ST_WR_REQ  = 4'd3,
        ST_WR_WAIT = 4'd4,
        ST_VF_REQ  = 4'd5,
        ST_VF_WAIT = 4'd6,
        ST_DONE    = 4'd7,
        ST_ERR     = 4'd8
    } state_t;
`else
    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_RD_REQ  = 4'd1,
        ST_RD_WAIT = 4'd2,
        ST_WR_REQ  = 4'd3,
        ST_WR_WAIT = 4'd4,
        ST_DONE    = 4'd7,
        ST_ERR     = 4'd8
    } state_t;
`endif

    state_t          state_r;
    logic [AW-1:0]   src_r;
    logic [AW-1:0]   dst_r;
    logic [LW-1:0]   rem_r;
    logic [DW-1:0]   data_r;
    logic [WDW-1:0]  wd_cnt_r;

    logic            in_req_s;
    logic            in_wait_s;
    logic            last_wait_s;
    logic            timeout_s;
    logic            abort_s;
    logic            word_done_s;

    assign wb_sel_o = {(DW/8){1'b1}};
    assign wb_dat_o = data_r;

    // Classify the current state and decide abort / word completion for this cycle.
    always_comb begin
        in_req_s    = 1'b0;
        in_wait_s   = 1'b0;
        last_wait_s = 1'b0;
        case (state_r)
            ST_RD_REQ, ST_WR_REQ: in_req_s = 1'b1;
            ST_RD_WAIT:           in_wait_s = 1'b1;
`ifdef WB_BOOT_COPIER_VERIFY_EN
            ST_WR_WAIT:           in_wait_s = 1'b1;
            ST_VF_REQ:            in_req_s = 1'b1;
            ST_VF_WAIT: begin
                in_wait_s   = 1'b1;
                last_wait_s = 1'b1;
            end
`else
            ST_WR_WAIT: begin
                in_wait_s   = 1'b1;
                last_wait_s = 1'b1;
            end
`endif
            default: begin
                in_req_s    = 1'b0;
                in_wait_s   = 1'b0;
                last_wait_s = 1'b0;
            end
        endcase
        timeout_s = WD_EN && (wd_cnt_r == WD_LAST);
        abort_s   = (in_wait_s && wb_err_i) || ((in_req_s || in_wait_s) && timeout_s);
`ifdef WB_BOOT_COPIER_VERIFY_EN
        if ((state_r == ST_VF_WAIT) && wb_ack_i && (wb_dat_i != data_r)) begin
            abort_s = 1'b1;
        end else begin
            abort_s = abort_s;
        end
`endif
        word_done_s = last_wait_s && wb_ack_i;
    end

    // Copy sequencer: bus handshake, address/count bookkeeping and status outputs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r    <= ST_IDLE;
            src_r      <= '0;
            dst_r      <= '0;
            rem_r      <= '0;
            data_r     <= '0;
            wd_cnt_r   <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            err_addr_o <= '0;
            wb_adr_o   <= '0;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_we_o    <= 1'b0;
        end else if (abort_s) begin
            // wb_adr_o still holds the address of the transaction in flight
            state_r    <= ST_ERR;
            err_o      <= 1'b1;
            err_addr_o <= wb_adr_o;
            busy_o     <= 1'b0;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_we_o    <= 1'b0;
        end else if (word_done_s) begin
            src_r    <= src_r + WORD_STEP;
            dst_r    <= dst_r + WORD_STEP;
            rem_r    <= rem_r - LW'(1'b1);
            wd_cnt_r <= '0;
            if (rem_r == LW'(1'b1)) begin
                state_r  <= ST_DONE;
                done_o   <= 1'b1;
                busy_o   <= 1'b0;
                wb_cyc_o <= 1'b0;
                wb_stb_o <= 1'b0;
                wb_we_o  <= 1'b0;
            end else begin
                state_r  <= ST_RD_REQ;
                wb_stb_o <= 1'b1;
                wb_we_o  <= 1'b0;
                wb_adr_o <= src_r + WORD_STEP;
            end
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start_i) begin
                        src_r      <= src_i;
                        dst_r      <= dst_i;
                        rem_r      <= len_i;
                        wd_cnt_r   <= '0;
                        done_o     <= 1'b0;
                        err_o      <= 1'b0;
                        err_addr_o <= '0;
                        if (len_i == '0) begin
                            state_r <= ST_DONE;
                            done_o  <= 1'b1;
                        end else begin
                            state_r  <= ST_RD_REQ;
                            busy_o   <= 1'b1;
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            wb_we_o  <= 1'b0;
                            wb_adr_o <= src_i;
                        end
                    end
                end
                ST_RD_REQ: begin
                    wd_cnt_r <= wd_cnt_r + WDW'(1'b1);
                    if (!wb_stall_i) begin
                        state_r  <= ST_RD_WAIT;
                        wb_stb_o <= 1'b0;
                    end
                end
                ST_RD_WAIT: begin
                    if (wb_ack_i) begin
                        state_r  <= ST_WR_REQ;
                        data_r   <= wb_dat_i;
                        wb_stb_o <= 1'b1;
                        wb_we_o  <= 1'b1;
                        wb_adr_o <= dst_r;
                        wd_cnt_r <= '0;
                    end else begin
                        wd_cnt_r <= wd_cnt_r + WDW'(1'b1);
                    end
                end
                ST_WR_REQ: begin
                    wd_cnt_r <= wd_cnt_r + WDW'(1'b1);
                    if (!wb_stall_i) begin
                        state_r  <= ST_WR_WAIT;
                        wb_stb_o <= 1'b0;
                    end
                end
`ifdef WB_BOOT_COPIER_VERIFY_EN
                ST_WR_WAIT: begin
                    if (wb_ack_i) begin
                        state_r  <= ST_VF_REQ;
                        wb_stb_o <= 1'b1;
                        wb_we_o  <= 1'b0;
                        wb_adr_o <= dst_r;
                        wd_cnt_r <= '0;
                    end else begin
                        wd_cnt_r <= wd_cnt_r + WDW'(1'b1);
                    end
                end
                ST_VF_REQ: begin
                    wd_cnt_r <= wd_cnt_r + WDW'(1'b1);
                    if (!wb_stall_i) begin
                        state_r  <= ST_VF_WAIT;
                        wb_stb_o <= 1'b0;
                    end
                end
                ST_VF_WAIT: begin
                    wd_cnt_r <= wd_cnt_r + WDW'(1'b1);
                end
`else
                ST_WR_WAIT: begin
                    wd_cnt_r <= wd_cnt_r + WDW'(1'b1);
                end
`endif
                default: begin
                    state_r  <= ST_IDLE;
                    busy_o   <= 1'b0;
                    wb_cyc_o <= 1'b0;
                    wb_stb_o <= 1'b0;
                    wb_we_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_boot_copier.sv
// Directed self-checking bench for wb_boot_copier with a behavioural Wishbone slave.
// Build with WB_BOOT_COPIER_VERIFY_EN defined to exercise the read-back variant.
`timescale 1ns/1ps
module tb_wb_boot_copier;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int LW      = 16;
    localparam int TIMEOUT = 8;
`ifdef WB_BOOT_COPIER_VERIFY_EN
    localparam int TPW = 3;
`else
    localparam int TPW = 2;
`endif
    localparam int CPW = 2 * TPW;

    logic            clk = 1'b0;
    logic            wb_rst_i;
    logic            start_i;
    logic [AW-1:0]   src_i;
    logic [AW-1:0]   dst_i;
    logic [LW-1:0]   len_i;
    logic            busy_o;
    logic            done_o;
    logic            err_o;
    logic [AW-1:0]   err_addr_o;
    logic [AW-1:0]   wb_adr_o;
    logic [DW-1:0]   wb_dat_o;
    logic [DW/8-1:0] wb_sel_o;
    logic            wb_cyc_o;
    logic            wb_stb_o;
    logic            wb_we_o;
    logic [DW-1:0]   wb_dat_i = 32'h0;
    logic            wb_stall_i = 1'b0;
    logic            wb_ack_i = 1'b0;
    logic            wb_err_i = 1'b0;

    wb_boot_copier #(.AW(AW), .DW(DW), .LW(LW), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .start_i(start_i),
        .src_i(src_i), .dst_i(dst_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_addr_o(err_addr_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_dat_i(wb_dat_i), .wb_stall_i(wb_stall_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    // Free-running bus clock.
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Slave knobs, written only by the stimulus process.
    int          stall_n     = 0;
    int          resp_delay  = 0;
    logic        hang_en     = 1'b0;
    logic        err_en      = 1'b0;
    logic        corrupt_en  = 1'b0;
    logic [31:0] err_adr     = 32'h0;
    logic [31:0] corrupt_adr = 32'h0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] log_adr[$];
    logic [31:0] log_dat[$];
    logic        log_we[$];

    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return pat(a);
    endfunction

    logic        pend = 1'b0;
    int          pend_wait = 0;
    int          stall_cnt = 0;
    logic        p_we = 1'b0;
    logic [31:0] p_adr = 32'h0;
    logic [31:0] p_dat = 32'h0;

    // Behavioural slave: responds on the falling edge so the DUT samples it cleanly.
    always @(negedge clk) begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = 32'h0;
        if (pend) begin
            if (pend_wait > 0) begin
                pend_wait--;
            end else begin
                pend = 1'b0;
                if (!hang_en) begin
                    if (p_we) begin
                        mem[p_adr] = p_dat;
                        wb_ack_i = 1'b1;
                    end else if (err_en && p_adr == err_adr) begin
                        wb_err_i = 1'b1;
                    end else begin
                        wb_dat_i = rd_word(p_adr) ^ ((corrupt_en && p_adr == corrupt_adr) ? 32'h1 : 32'h0);
                        wb_ack_i = 1'b1;
                    end
                end
            end
        end
        wb_stall_i = 1'b0;
        if (wb_cyc_o === 1'b1 && wb_stb_o === 1'b1 && !pend) begin
            if (stall_cnt < stall_n) begin
                wb_stall_i = 1'b1;
                stall_cnt++;
            end else begin
                stall_cnt = 0;
                pend      = 1'b1;
                pend_wait = resp_delay;
                p_we      = wb_we_o;
                p_adr     = wb_adr_o;
                p_dat     = wb_dat_o;
                log_adr.push_back(wb_adr_o);
                log_we.push_back(wb_we_o);
                log_dat.push_back(wb_dat_o);
            end
        end
    end

    int          cyc_cycles = 0;
    int          stb_cycles = 0;
    int          gap_cycles = 0;
    int          stall_viol = 0;
    logic        was_stalled = 1'b0;
    logic [31:0] held_adr = 32'h0;

    // Bus monitor: cyc/stb activity, cyc gaps during a copy, request stability under stall.
    always @(posedge clk) begin
        if (wb_cyc_o === 1'b1) cyc_cycles++;
        if (wb_stb_o === 1'b1) stb_cycles++;
        if (busy_o === 1'b1 && wb_cyc_o !== 1'b1) gap_cycles++;
        if (was_stalled && !(wb_stb_o === 1'b1 && wb_adr_o == held_adr)) stall_viol++;
        was_stalled = (wb_cyc_o === 1'b1) && (wb_stb_o === 1'b1) && wb_stall_i;
        held_adr    = wb_adr_o;
    end

    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                            input int poke, output int k);
        @(negedge clk);
        src_i   = s;
        dst_i   = d;
        len_i   = l;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        k = 0;
        while (!(done_o === 1'b1 || err_o === 1'b1) && k < 400) begin
            @(posedge clk); #1;
            k++;
            if (k == poke) begin
                start_i = 1'b1;
                src_i   = 32'hDEAD_0000;
                len_i   = 16'd0;
            end else begin
                start_i = 1'b0;
            end
        end
        start_i = 1'b0;
        check_eq("wait_bound", (k < 400), 1'b1);
    endtask

    // Directed test sequence.
    initial begin
        int k;
        int base;
        int c0;
        int s0;
        int g0;
        int v0;
        wb_rst_i = 1'b1;
        start_i  = 1'b0;
        src_i    = 32'h0;
        dst_i    = 32'h0;
        len_i    = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", busy_o, 1'b0);
        check_eq("rst_done", done_o, 1'b0);
        check_eq("rst_err", err_o, 1'b0);
        check_eq("rst_err_addr", err_addr_o, 32'h0);
        check_eq("rst_adr", wb_adr_o, 32'h0);
        check_eq("rst_dat", wb_dat_o, 32'h0);
        check_eq("rst_cyc", wb_cyc_o, 1'b0);
        check_eq("rst_stb", wb_stb_o, 1'b0);
        check_eq("rst_we", wb_we_o, 1'b0);
        check_eq("rst_sel", wb_sel_o, 4'hF);
        wb_rst_i = 1'b0;

        // Basic copy, no stall, ack one cycle after acceptance.
        base = log_adr.size();
        g0   = gap_cycles;
        run_copy(32'h0000_0000, 32'h0010_0000, 16'd4, -1, k);
        check_eq("basic_cycles", k, 4 * CPW);
        check_eq("basic_done", done_o, 1'b1);
        check_eq("basic_busy", busy_o, 1'b0);
        check_eq("basic_cyc", wb_cyc_o, 1'b0);
        check_eq("basic_ntrans", log_adr.size() - base, 4 * TPW);
        for (int i = 0; i < 4; i++) begin
            check_eq("basic_rd_adr", log_adr[base + i * TPW], 32'h0000_0000 + 32'(4 * i));
            check_eq("basic_rd_we", log_we[base + i * TPW], 1'b0);
            check_eq("basic_wr_adr", log_adr[base + i * TPW + 1], 32'h0010_0000 + 32'(4 * i));
            check_eq("basic_wr_we", log_we[base + i * TPW + 1], 1'b1);
            check_eq("basic_wr_dat", log_dat[base + i * TPW + 1], pat(32'h0000_0000 + 32'(4 * i)));
            check_eq("basic_mem", rd_word(32'h0010_0000 + 32'(4 * i)), pat(32'h0000_0000 + 32'(4 * i)));
        end
        check_eq("basic_cyc_gap", gap_cycles - g0, 0);

        // Three stall cycles on every request; a start pulse mid-copy must be ignored.
        stall_n = 3;
        base = log_adr.size();
        v0   = stall_viol;
        run_copy(32'h0000_0100, 32'h0020_0000, 16'd2, 3, k);
        check_eq("stall_cycles", k, 2 * TPW * (2 + 3));
        check_eq("stall_done", done_o, 1'b1);
        check_eq("stall_hold", stall_viol - v0, 0);
        check_eq("stall_ntrans", log_adr.size() - base, 2 * TPW);
        check_eq("stall_rd1_adr", log_adr[base + TPW], 32'h0000_0104);
        check_eq("stall_mem0", rd_word(32'h0020_0000), pat(32'h0000_0100));
        check_eq("stall_mem1", rd_word(32'h0020_0004), pat(32'h0000_0104));
        stall_n = 0;

        // Zero length: done next cycle, no bus activity.
        c0   = cyc_cycles;
        s0   = stb_cycles;
        base = log_adr.size();
        run_copy(32'h0000_0400, 32'h0000_0500, 16'd0, -1, k);
        check_eq("zero_cycles", k, 0);
        check_eq("zero_done", done_o, 1'b1);
        check_eq("zero_busy", busy_o, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("zero_cyc", cyc_cycles - c0, 0);
        check_eq("zero_stb", stb_cycles - s0, 0);
        check_eq("zero_ntrans", log_adr.size() - base, 0);

        // Error response on the third read.
        err_en  = 1'b1;
        err_adr = 32'h0000_1008;
        run_copy(32'h0000_1000, 32'h0030_0000, 16'd4, -1, k);
        check_eq("err_cycles", k, 2 * CPW + 2);
        check_eq("err_flag", err_o, 1'b1);
        check_eq("err_addr", err_addr_o, 32'h0000_1008);
        check_eq("err_done", done_o, 1'b0);
        check_eq("err_busy", busy_o, 1'b0);
        check_eq("err_cyc", wb_cyc_o, 1'b0);
        check_eq("err_stb", wb_stb_o, 1'b0);
        err_en = 1'b0;

        // Watchdog: first read is never answered.
        hang_en = 1'b1;
        run_copy(32'h0000_2000, 32'h0040_0000, 16'd3, -1, k);
        check_eq("tmo_cycles", k, TIMEOUT);
        check_eq("tmo_flag", err_o, 1'b1);
        check_eq("tmo_addr", err_addr_o, 32'h0000_2000);
        check_eq("tmo_busy", busy_o, 1'b0);
        check_eq("tmo_cyc", wb_cyc_o, 1'b0);
        hang_en = 1'b0;
        repeat (2) @(posedge clk);

        // Reset while in WR_WAIT, with the write ack arriving after the reset.
        resp_delay = 2;
        @(negedge clk);
        src_i   = 32'h0000_3000;
        dst_i   = 32'h0050_0000;
        len_i   = 16'd2;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        k = 0;
        while (!(wb_we_o === 1'b1 && wb_cyc_o === 1'b1 && wb_stb_o === 1'b0) && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check_eq("mid_reach_wr_wait", (k < 50), 1'b1);
        wb_rst_i = 1'b1;
        @(posedge clk); #1;
        wb_rst_i = 1'b0;
        check_eq("mid_busy", busy_o, 1'b0);
        check_eq("mid_cyc", wb_cyc_o, 1'b0);
        check_eq("mid_stb", wb_stb_o, 1'b0);
        check_eq("mid_we", wb_we_o, 1'b0);
        check_eq("mid_adr", wb_adr_o, 32'h0);
        check_eq("mid_dat", wb_dat_o, 32'h0);
        c0 = cyc_cycles;
        repeat (6) @(posedge clk);
        #1;
        check_eq("late_ack_busy", busy_o, 1'b0);
        check_eq("late_ack_done", done_o, 1'b0);
        check_eq("late_ack_err", err_o, 1'b0);
        check_eq("late_ack_cyc", cyc_cycles - c0, 0);
        resp_delay = 0;
        run_copy(32'h0000_5000, 32'h0060_0000, 16'd3, -1, k);
        check_eq("restart_cycles", k, 3 * CPW);
        check_eq("restart_done", done_o, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check_eq("restart_mem", rd_word(32'h0060_0000 + 32'(4 * i)), pat(32'h0000_5000 + 32'(4 * i)));
        end

`ifdef WB_BOOT_COPIER_VERIFY_EN
        // Read-back of word 1 returns corrupted data.
        corrupt_en  = 1'b1;
        corrupt_adr = 32'h0070_0004;
        run_copy(32'h0000_6000, 32'h0070_0000, 16'd3, -1, k);
        check_eq("vf_cycles", k, 2 * CPW);
        check_eq("vf_flag", err_o, 1'b1);
        check_eq("vf_addr", err_addr_o, 32'h0070_0004);
        check_eq("vf_busy", busy_o, 1'b0);
        corrupt_en = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
